mem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the single-port 256x16 data memory (mem: din, addr, we, dout).

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_if.sv | 32 +++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: default address/data widths, FSM state encoding, port index constants.
package mem_arb_pkg;

   localparam int AW_DEF = 8;    // mem depth 2**AW_DEF
   localparam int DW_DEF = 16;

   localparam logic PORT0 = 1'b0;   // fetch stage
   localparam logic PORT1 = 1'b1;   // load/store stage

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the two requester ports plus the single-port memory side.
// Latency: n/a (wiring only).
// Backpressure: a requester holds reqN and its payload until gntN pulses.
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_arb_if
   import mem_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          req0, req1;
   logic          we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] din0, din1;
   logic          gnt0, gnt1;
   logic          rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic          mem_we;
   logic [DW-1:0] mem_dout;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, din0, din1, mem_dout,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_din, mem_we
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, din0, din1, mem_dout,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_din, mem_we
   );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner select between the two requesters (MEM_ARB_RR_EN: round-robin ties, else port 0 wins).
// Latency: combinational.
// Backpressure: none; the caller only acts on sel_o when any_o is high.
// Ports: req0_i/req1_i requests, last_i port granted last, sel_o winning port, any_o request present.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic sel_o,
   output logic any_o
);

   assign any_o = req0_i | req1_i;

`ifdef MEM_ARB_RR_EN
   // On a tie port 1 wins only if port 0 was the most recent winner.
   assign sel_o = req1_i & (~req0_i | (last_i == PORT0));
`else
   // Fixed priority: port 1 is picked only when port 0 is silent.
   logic unused_last;
   assign unused_last = last_i;
   assign sel_o = req1_i & ~req0_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Sequences two requesters onto one single-port memory (macro MEM_ARB_RR_EN selects round-robin ties).
// Latency: gnt and mem access 1 clk after req is sampled in IDLE; read data valid 1 clk after that.
// Backpressure: one access per 2 clk; a losing requester keeps req high and is re-arbitrated next IDLE.
// Ports: clk, rst (sync, active-high), bus (mem_arb_if.slave: requester ports and mem side).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
)(
   input  logic     clk,
   input  logic     rst,
   mem_arb_if.slave bus
);

   state_t        state_q, state_d;
   logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_din_q, mem_din_d;
   logic          port_q, port_d;     // port owning the current access
   logic          rd_q, rd_d;         // current access is a read
   logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic          last_w, sel_w, any_w;

`ifdef MEM_ARB_RR_EN
   logic last_q, last_d;

   // Pointer starts at port 1 so port 0 takes the first tie after reset.
   always_ff @(posedge clk) begin
      if (rst) last_q <= PORT1;
      else     last_q <= last_d;
   end

   always_comb begin
      last_d = last_q;
      if (state_q == ST_IDLE && any_w) last_d = sel_w;
   end

   assign last_w = last_q;
`else
   assign last_w = PORT1;
`endif

   mem_arb_pick u_pick (
      .req0_i (bus.req0),
      .req1_i (bus.req1),
      .last_i (last_w),
      .sel_o  (sel_w),
      .any_o  (any_w)
   );

   always_comb begin
      state_d    = state_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      port_d     = port_q;
      rd_d       = 1'b0;
      rvalid0_d  = 1'b0;
      rvalid1_d  = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      case (state_q)
         ST_IDLE: begin
            if (any_w) begin
               state_d = ST_ACCESS;
               port_d  = sel_w;
               if (sel_w == PORT1) begin
                  mem_addr_d = bus.addr1;
                  mem_din_d  = bus.din1;
                  mem_we_d   = bus.we1;
                  rd_d       = ~bus.we1;
                  gnt1_d     = 1'b1;
               end else begin
                  mem_addr_d = bus.addr0;
                  mem_din_d  = bus.din0;
                  mem_we_d   = bus.we0;
                  rd_d       = ~bus.we0;
                  gnt0_d     = 1'b1;
               end
            end
         end
         ST_ACCESS: begin
            // mem_dout is a combinational read of the registered address, so it is valid now.
            state_d = ST_IDLE;
            if (rd_q) begin
               if (port_q == PORT1) begin
                  rdata1_d  = bus.mem_dout;
                  rvalid1_d = 1'b1;
               end else begin
                  rdata0_d  = bus.mem_dout;
                  rvalid0_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         port_q     <= PORT0;
         rd_q       <= 1'b0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         port_q     <= port_d;
         rd_q       <= rd_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   assign bus.gnt0     = gnt0_q;
   assign bus.gnt1     = gnt1_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
   assign bus.rvalid0  = rvalid0_q;
   assign bus.rvalid1  = rvalid1_q;
   assign bus.rdata0   = rdata0_q;
   assign bus.rdata1   = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-port traffic against a reference model.
// Latency: n/a.
// Backpressure: requesters hold req until gnt, as a real pipeline stage would.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arb_if bus ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end else begin
         passes++;
      end
   endtask

   function automatic logic [DW_DEF-1:0] init_val(input int i);
      return DW_DEF'(i * 257) ^ 16'hA55A;
   endfunction

   // Memory the arbiter drives: combinational read, write on the edge while mem_we is high.
   logic [DW_DEF-1:0] mem_arr [256];
   assign bus.mem_dout = mem_arr[bus.mem_addr];

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_din;
      end
   end

   // ---------------- reference model + scoreboard ----------------
   logic [DW_DEF-1:0] ref_mem [256];
   logic [DW_DEF-1:0] q0 [$];
   logic [DW_DEF-1:0] q1 [$];
   bit                glog_port [$];
   int                glog_cyc [$];
   int                rv0_cnt = 0;
   int                cyc_n = 0;

   // Inputs as seen by the edge that closes each cycle.
   logic              s_rst = 1'b1;
   logic              s_req0 = 1'b0, s_req1 = 1'b0, s_we0 = 1'b0, s_we1 = 1'b0;
   logic [AW_DEF-1:0] s_addr0 = '0, s_addr1 = '0;
   logic [DW_DEF-1:0] s_din0 = '0, s_din1 = '0;
   bit                was_gnt = 1'b0, m_last = 1'b1;
   bit                exp_rv0 = 1'b0, exp_rv1 = 1'b0;

   initial begin : monitor
      bit                exp_any, win, wwe;
      logic [1:0]        exp_g;
      logic [AW_DEF-1:0] wa;
      logic [DW_DEF-1:0] wd, e;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      forever begin
         @(negedge clk);
         cyc_n++;
         if (bus.rvalid0) rv0_cnt++;
         if (s_rst) begin
            check("reset_outputs",
                  {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_we,
                   bus.mem_addr, bus.mem_din, bus.rdata0, bus.rdata1}, 64'd0);
            q0.delete();
            q1.delete();
            exp_rv0 = 1'b0;
            exp_rv1 = 1'b0;
            m_last  = 1'b1;
            was_gnt = 1'b0;
         end else begin
            if (bus.rvalid0 || exp_rv0) check("rvalid0", bus.rvalid0, exp_rv0);
            if (bus.rvalid1 || exp_rv1) check("rvalid1", bus.rvalid1, exp_rv1);
            if (exp_rv0 && q0.size() > 0) begin e = q0.pop_front(); check("rdata0", bus.rdata0, e); end
            if (exp_rv1 && q1.size() > 0) begin e = q1.pop_front(); check("rdata1", bus.rdata1, e); end
            exp_rv0 = 1'b0;
            exp_rv1 = 1'b0;

            // One access per two cycles: a request is taken only if the previous cycle had no grant.
            exp_any = (s_req0 | s_req1) && !was_gnt;
            if (s_req0 && s_req1) win = RR ? (m_last == 1'b0) : 1'b0;
            else                  win = s_req1;
            exp_g = exp_any ? (win ? 2'b10 : 2'b01) : 2'b00;
            if (exp_any || bus.gnt0 || bus.gnt1) check("gnt", {bus.gnt1, bus.gnt0}, exp_g);
            if (bus.gnt0 || bus.gnt1) begin
               glog_port.push_back(bus.gnt1);
               glog_cyc.push_back(cyc_n);
            end
            if (exp_any) begin
               wwe = win ? s_we1   : s_we0;
               wa  = win ? s_addr1 : s_addr0;
               wd  = win ? s_din1  : s_din0;
               check("mem_we",   bus.mem_we,   wwe);
               check("mem_addr", bus.mem_addr, wa);
               check("mem_din",  bus.mem_din,  wd);
               if (wwe) ref_mem[wa] = wd;
               else if (win) begin q1.push_back(ref_mem[wa]); exp_rv1 = 1'b1; end
               else          begin q0.push_back(ref_mem[wa]); exp_rv0 = 1'b1; end
               m_last = win;
            end else if (bus.mem_we) begin
               check("mem_we_idle", bus.mem_we, 1'b0);
            end
            was_gnt = exp_any;
         end
         s_rst  = rst;
         s_req0 = bus.req0;  s_req1 = bus.req1;
         s_we0  = bus.we0;   s_we1  = bus.we1;
         s_addr0 = bus.addr0; s_addr1 = bus.addr1;
         s_din0 = bus.din0;  s_din1 = bus.din1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_gnt(input bit port, input bit drop);
      bit got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = port ? bus.gnt1 : bus.gnt0;
      end
      checks++;
      if (!got) begin
         fails++;
         $display("FAIL gnt%0d_timeout: got no grant in 50 cycles, required a grant", port);
      end else begin
         passes++;
      end
      @(posedge clk);
      #1;
      if (drop) begin
         if (port) bus.req1 = 1'b0;
         else      bus.req0 = 1'b0;
      end
   endtask

   task automatic issue(input bit port, input bit we, input logic [AW_DEF-1:0] a,
                        input logic [DW_DEF-1:0] d);
      @(posedge clk);
      #1;
      if (port) begin bus.we1 = we; bus.addr1 = a; bus.din1 = d; bus.req1 = 1'b1; end
      else      begin bus.we0 = we; bus.addr0 = a; bus.din0 = d; bus.req0 = 1'b1; end
      wait_gnt(port, 1'b1);
   endtask

   task automatic rand_issue(input bit port);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue(port, 1'($urandom_range(0, 1)), AW_DEF'($urandom_range(0, 15)), DW_DEF'($urandom));
   endtask

   initial begin : stim
      int base, rvb;
      int exp_order [4];
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10; bus.din0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0;    bus.din1 = '0;

      // Reset held 2 clk with port 0 already requesting; grant only after release.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wait_gnt(1'b0, 1'b1);

      // Write from load/store port; leaves the pointer on port 1.
      issue(1'b1, 1'b1, 8'h07, 16'hFFFF);

      // Tie held through four grants.
      @(posedge clk);
      #1;
      bus.we0 = 1'b0; bus.addr0 = 8'h20; bus.req0 = 1'b1;
      bus.we1 = 1'b0; bus.addr1 = 8'h21; bus.req1 = 1'b1;
      base = glog_port.size();
      for (int i = 0; i < 60 && glog_port.size() < base + 4; i++) @(posedge clk);
      #1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      if (RR) exp_order = '{0, 1, 0, 1};
      else    exp_order = '{0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         if (glog_port.size() > base + i) check($sformatf("tie_order%0d", i), glog_port[base + i], exp_order[i]);
         else check($sformatf("tie_count%0d", i), glog_port.size(), base + 4);
      end

      // Read back the written word through the fetch port.
      issue(1'b0, 1'b0, 8'h07, 16'h0000);

      // Abort a port 0 read with reset during its access cycle.
      repeat (3) @(posedge clk);
      #1;
      bus.we0 = 1'b0; bus.addr0 = 8'h07; bus.req0 = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.req0 = 1'b0;
      @(negedge clk);
      check("abort_gnt0", bus.gnt0, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_rvalid0", bus.rvalid0, 1'b0);
      check("abort_mem_we", bus.mem_we, 1'b0);

      // Back-to-back reads 0x00..0x03 with req0 held throughout.
      @(posedge clk);
      #1;
      rvb  = rv0_cnt;
      base = glog_cyc.size();
      bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.req0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(1'b0, 1'b0);
         bus.addr0 = AW_DEF'(i + 1);
      end
      bus.req0 = 1'b0;
      repeat (3) @(posedge clk);
      for (int i = 1; i < 4; i++)
         if (glog_cyc.size() > base + i)
            check($sformatf("b2b_spacing%0d", i), glog_cyc[base + i] - glog_cyc[base + i - 1], 2);
      check("b2b_rvalid_count", rv0_cnt - rvb, 4);

      // Random traffic on both ports.
      for (int n = 0; n < 40; n++) begin
         fork
            begin if ($urandom_range(0, 3) != 0) rand_issue(1'b0); end
            begin if ($urandom_range(0, 3) != 0) rand_issue(1'b1); end
         join
      end

      repeat (5) @(posedge clk);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
